// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle,
// WIDTH steps per product. done_o flags the cycle whose step completes the product.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);
    localparam int CW = $clog2(WIDTH);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH:0]       hi_sum;

    // Low half of acc_q starts as the multiplier and drains out as the product shifts in.
    always_comb begin
        hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d  = {hi_sum, acc_q[WIDTH-1:1]};
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a_i;
            acc_q   <= {{WIDTH{1'b0}}, b_i};
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered integer ALU with valid/ready on both sides and an iterative multiplier.
// Handshake: a transfer occurs on a rising edge where valid && ready; valid never waits on ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             zero
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               ovf_q, ovf_d;
    logic               cy_q, cy_d;

    logic [WIDTH-1:0]   res;
    logic               res_ovf, res_cy;
    logic [WIDTH:0]     add_w, sub_w, neg_w;
    logic [SHW-1:0]     sh;

    logic               accept, mul_start, mul_done, ld_alu, ld_mul;
    logic [2*WIDTH-1:0] prod;

    assign sh = b[SHW-1:0];

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_cy  = 1'b0;
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        neg_w   = {(WIDTH+1){1'b0}} - {1'b0, a};
        case (f)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
                res     = add_w[WIDTH-1:0];
                res_cy  = add_w[WIDTH];
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res     = sub_w[WIDTH-1:0];
                res_cy  = sub_w[WIDTH];
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NEG: begin
                res     = neg_w[WIDTH-1:0];
                res_cy  = neg_w[WIDTH];
                res_ovf = a[WIDTH-1] && (a[WIDTH-2:0] == '0);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $signed(a) >>> sh;
            default: res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (a),
        .b_i     (b),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Acceptance looks the same from IDLE and from a consuming DONE, so it is folded here.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        ld_alu    = 1'b0;
        ld_mul    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (f == OP_MUL) begin
                        state_d   = ST_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        ld_alu  = 1'b1;
                    end
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    ld_mul  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_d   = s_q;
        ovf_d = ovf_q;
        cy_d  = cy_q;
        if (ld_mul) begin
            s_d   = prod[WIDTH-1:0];
            ovf_d = |prod[2*WIDTH-1:WIDTH];
            cy_d  = 1'b0;
        end else if (ld_alu) begin
            s_d   = res;
            ovf_d = res_ovf;
            cy_d  = res_cy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            cy_q    <= cy_d;
        end
    end

    assign s        = s_q;
    assign overflow = ovf_q;
    assign carry    = cy_q;
    assign negative = s_q[WIDTH-1];
    assign zero     = (s_q == '0);

endmodule
